// File: rtl/iter_shifter.sv
// Iterative barrel-less shifter: LSL/LSR/ASR/ROR/RRX applied at most STEP bits per cycle.
// Valid/ready handshake on both sides; one operation in flight at a time.
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [WIDTH-1:0] operand_in,
  input  logic [AMT_W-1:0] amount_in,
  input  logic [1:0]       type_in,
  input  logic             imm_mode_in,
  input  logic             carry_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [WIDTH-1:0] result_out,
  output logic             carry_out
);

  localparam int LW    = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam int EW    = ((AMT_W > CNT_W) ? AMT_W : CNT_W) + 1;
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
  typedef enum logic [1:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR} op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic               rrx_q, rrx_d;
  logic [WIDTH-1:0]   val_q, val_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   rem_q, rem_d;

  logic [EW-1:0]      amt_x;
  logic [LW-1:0]      imm_a;
  logic [CNT_W-1:0]   eff_amt;
  logic               eff_rrx;
  logic [CNT_W-1:0]   step_k;
  logic [WIDTH:0]     wide;
  logic [WIDTH-1:0]   sh_val;
  logic               sh_carry;

  always_comb begin
    amt_x   = EW'(amount_in);
    imm_a   = amount_in[LW-1:0];
    eff_amt = '0;
    eff_rrx = 1'b0;
    if (imm_mode_in) begin
      case (op_e'(type_in))
        OP_LSL:         eff_amt = CNT_W'(imm_a);
        OP_LSR, OP_ASR: eff_amt = (imm_a == '0) ? WIDTH_C : CNT_W'(imm_a);
        default: begin
          if (imm_a == '0) begin
            eff_amt = CNT_W'(1);
            eff_rrx = 1'b1;
          end else begin
            eff_amt = CNT_W'(imm_a);
          end
        end
      endcase
    end else begin
      case (op_e'(type_in))
        OP_LSL, OP_LSR: eff_amt = (amt_x > EW'(WIDTH + 1)) ? CNT_W'(WIDTH + 1) : CNT_W'(amt_x);
        OP_ASR:         eff_amt = (amt_x > EW'(WIDTH)) ? WIDTH_C : CNT_W'(amt_x);
        default:        eff_amt = (amt_x == '0) ? '0 :
                                  CNT_W'(((amt_x - EW'(1)) & EW'(WIDTH - 1)) + EW'(1));
      endcase
    end
  end

  // The carry flag rides one bit beyond the operand so it naturally captures the last bit out.
  always_comb begin
    step_k   = (rem_q > STEP_C) ? STEP_C : rem_q;
    wide     = '0;
    sh_val   = val_q;
    sh_carry = carry_q;
    case (op_q)
      OP_LSL: begin
        wide     = {carry_q, val_q} << step_k;
        sh_val   = wide[WIDTH-1:0];
        sh_carry = wide[WIDTH];
      end
      OP_LSR: begin
        wide     = {val_q, carry_q} >> step_k;
        sh_val   = wide[WIDTH:1];
        sh_carry = wide[0];
      end
      OP_ASR: begin
        wide     = $signed({val_q, carry_q}) >>> step_k;
        sh_val   = wide[WIDTH:1];
        sh_carry = wide[0];
      end
      default: begin
        if (rrx_q) begin
          sh_val   = {carry_q, val_q[WIDTH-1:1]};
          sh_carry = val_q[0];
        end else begin
          sh_val   = (val_q >> step_k) | (val_q << (WIDTH_C - step_k));
          sh_carry = sh_val[WIDTH-1];
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rrx_d   = rrx_q;
    val_d   = val_q;
    carry_d = carry_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_in) begin
          val_d   = operand_in;
          carry_d = carry_in;
          op_d    = op_e'(type_in);
          rrx_d   = eff_rrx;
          rem_d   = eff_amt;
          state_d = (eff_amt != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        val_d   = sh_val;
        carry_d = sh_carry;
        rem_d   = rem_q - step_k;
        if (rem_q == step_k) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LSL;
      rrx_q   <= 1'b0;
      val_q   <= '0;
      carry_q <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rrx_q   <= rrx_d;
      val_q   <= val_d;
      carry_q <= carry_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready_out  = (state_q == ST_IDLE);
  assign out_valid_out = (state_q == ST_DONE);
  assign result_out    = val_q;
  assign carry_out     = carry_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Randomised and directed checks of iter_shifter against a bit-at-a-time reference model.
module tb_iter_shifter;

  localparam int W    = 32;
  localparam int STEP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid_in;
  logic          in_ready_out;
  logic [W-1:0]  operand_in;
  logic [7:0]    amount_in;
  logic [1:0]    type_in;
  logic          imm_mode_in;
  logic          carry_in;
  logic          out_valid_out;
  logic          out_ready_in;
  logic [W-1:0]  result_out;
  logic          carry_out;

  int n_tests = 0;
  int n_fail  = 0;

  iter_shifter #(.WIDTH(W), .STEP(STEP), .AMT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_in(in_valid_in), .in_ready_out(in_ready_out),
    .operand_in(operand_in), .amount_in(amount_in), .type_in(type_in),
    .imm_mode_in(imm_mode_in), .carry_in(carry_in),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
    .result_out(result_out), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Effective amount from the encoding rules, then one bit per iteration.
  function automatic void model(input logic [W-1:0] op, input logic [7:0] amt,
                                input logic [1:0] ty, input logic imm, input logic cin,
                                output logic [W-1:0] res, output logic co, output int lat);
    int unsigned e;
    int unsigned a;
    int unsigned n;
    logic        rrx;
    logic        msb;
    rrx = 1'b0;
    n   = amt;
    a   = n % W;
    if (imm) begin
      case (ty)
        2'd0:    e = a;
        2'd1,
        2'd2:    e = (a == 0) ? W : a;
        default: begin
          e   = (a == 0) ? 1 : a;
          rrx = (a == 0);
        end
      endcase
    end else begin
      case (ty)
        2'd0,
        2'd1:    e = (n > W + 1) ? W + 1 : n;
        2'd2:    e = (n > W) ? W : n;
        default: e = (n == 0) ? 0 : ((n - 1) % W) + 1;
      endcase
    end
    res = op;
    co  = cin;
    msb = op[W-1];
    for (int unsigned i = 0; i < e; i++) begin
      case (ty)
        2'd0:    begin co = res[W-1]; res = res << 1; end
        2'd1:    begin co = res[0];   res = res >> 1; end
        2'd2:    begin co = res[0];   res = {msb, res[W-1:1]}; end
        default: begin co = res[0];   res = {(rrx ? cin : res[0]), res[W-1:1]}; end
      endcase
    end
    lat = int'((e + STEP - 1) / STEP) + 1;
  endfunction

  task automatic run_op(input logic [W-1:0] op, input logic [7:0] amt, input logic [1:0] ty,
                        input logic imm, input logic cin, input int hold,
                        output logic [W-1:0] res, output logic co, output int lat);
    logic [W-1:0] eres;
    logic         eco;
    int           elat;
    model(op, amt, ty, imm, cin, eres, eco, elat);
    @(negedge clk);
    check_eq("idle_ready", 64'(in_ready_out), 64'd1);
    operand_in  = op;
    amount_in   = amt;
    type_in     = ty;
    imm_mode_in = imm;
    carry_in    = cin;
    in_valid_in = 1'b1;
    @(posedge clk); #1;
    in_valid_in = 1'b0;
    lat = 1;
    while (!out_valid_out && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("out_valid", 64'(out_valid_out), 64'd1);
    check_eq("latency", 64'(lat), 64'(elat));
    check_eq("result", 64'(result_out), 64'(eres));
    check_eq("carry", 64'(carry_out), 64'(eco));
    res = result_out;
    co  = carry_out;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid_in = 1'b1;
      operand_in  = $urandom;
      amount_in   = 8'($urandom);
      @(posedge clk); #1;
      check_eq("hold_valid", 64'(out_valid_out), 64'd1);
      check_eq("hold_ready", 64'(in_ready_out), 64'd0);
      check_eq("hold_result", 64'(result_out), 64'(eres));
      check_eq("hold_carry", 64'(carry_out), 64'(eco));
    end
    @(negedge clk);
    in_valid_in  = 1'b0;
    out_ready_in = 1'b1;
    @(posedge clk); #1;
    check_eq("release_ready", 64'(in_ready_out), 64'd1);
    check_eq("release_valid", 64'(out_valid_out), 64'd0);
    out_ready_in = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r;
    logic         c;
    int           l;
    logic         seen;
    logic [7:0]   amt;
    rst_n = 1'b0; in_valid_in = 1'b0; out_ready_in = 1'b0;
    operand_in = '0; amount_in = '0; type_in = '0; imm_mode_in = 1'b0; carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(in_ready_out), 64'd1);
    check_eq("rst_valid", 64'(out_valid_out), 64'd0);
    check_eq("rst_result", 64'(result_out), 64'd0);
    check_eq("rst_carry", 64'(carry_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h8000_0001, 8'd5, 2'd0, 1'b0, 1'b0, 0, r, c, l);
    check_eq("lsl5_res", 64'(r), 64'h20);
    check_eq("lsl5_c", 64'(c), 64'd0);
    check_eq("lsl5_lat", 64'(l), 64'd3);
    run_op(32'h8000_0000, 8'd0, 2'd1, 1'b1, 1'b0, 0, r, c, l);
    check_eq("lsr_imm0_res", 64'(r), 64'h0);
    check_eq("lsr_imm0_c", 64'(c), 64'd1);
    check_eq("lsr_imm0_lat", 64'(l), 64'd9);
    run_op(32'h0000_0003, 8'd0, 2'd3, 1'b1, 1'b1, 0, r, c, l);
    check_eq("rrx_res", 64'(r), 64'h8000_0001);
    check_eq("rrx_c", 64'(c), 64'd1);
    check_eq("rrx_lat", 64'(l), 64'd2);
    run_op(32'h8000_0000, 8'd40, 2'd2, 1'b0, 1'b0, 0, r, c, l);
    check_eq("asr40_res", 64'(r), 64'hFFFF_FFFF);
    check_eq("asr40_c", 64'(c), 64'd1);
    run_op(32'h8000_0000, 8'd32, 2'd3, 1'b0, 1'b0, 0, r, c, l);
    check_eq("ror32_res", 64'(r), 64'h8000_0000);
    check_eq("ror32_c", 64'(c), 64'd1);
    run_op(32'hFFFF_FFFF, 8'd33, 2'd0, 1'b0, 1'b1, 0, r, c, l);
    check_eq("lsl33_res", 64'(r), 64'h0);
    check_eq("lsl33_c", 64'(c), 64'd0);
    run_op(32'h1234_5678, 8'd7, 2'd1, 1'b0, 1'b0, 3, r, c, l);

    @(negedge clk);
    operand_in = 32'hDEAD_BEEF; amount_in = 8'd32; type_in = 2'd1; imm_mode_in = 1'b0;
    carry_in = 1'b0; in_valid_in = 1'b1;
    @(posedge clk); #1;
    in_valid_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_ready", 64'(in_ready_out), 64'd1);
    check_eq("midrst_valid", 64'(out_valid_out), 64'd0);
    check_eq("midrst_result", 64'(result_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen = seen | out_valid_out;
    end
    check_eq("midrst_no_result", 64'(seen), 64'd0);
    run_op(32'hCAFE_F00D, 8'd0, 2'd0, 1'b0, 1'b1, 0, r, c, l);
    check_eq("post_rst_res", 64'(r), 64'hCAFE_F00D);
    check_eq("post_rst_c", 64'(c), 64'd1);
    check_eq("post_rst_lat", 64'(l), 64'd1);

    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 5))
        0:       amt = 8'd0;
        1:       amt = 8'd1;
        2:       amt = 8'(W - 1 + $urandom_range(0, 2));
        3:       amt = 8'(W + $urandom_range(32, 100));
        default: amt = 8'($urandom);
      endcase
      run_op($urandom, amt, 2'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), r, c, l);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_shifter.md
ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; power of two, >= 8.
REQ-002 SHALL have parameter STEP, default 4, max bits shifted per cycle; power of two, 1..WIDTH.
REQ-003 SHALL have parameter AMT_W, default 8, register shift-amount width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid_in  input  1  request valid.
REQ-007 in_ready_out  output  1  unit can accept request.
REQ-008 operand_in  input  WIDTH  value to shift.
REQ-009 amount_in  input  AMT_W  shift amount; only low log2(WIDTH) bits used when imm_mode_in=1.
REQ-010 type_in  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-011 imm_mode_in  input  1  1 = immediate-encoded amount, 0 = register amount.
REQ-012 carry_in  input  1  current carry flag.
REQ-013 out_valid_out  output  1  result valid.
REQ-014 out_ready_in  input  1  consumer accepts result.
REQ-015 result_out  output  WIDTH  shifted value.
REQ-016 carry_out  output  1  shifter carry out.

Function
REQ-017 SHALL implement FSM IDLE, SHIFT, DONE; in_ready_out=1 only in IDLE; out_valid_out=1 only in DONE.
REQ-018 IDLE: on in_valid_in=1, SHALL register operand, type, carry_in, effective amount E; go SHIFT if E>0, else DONE.
REQ-019 Register mode E: LSL/LSR min(amount,WIDTH+1); ASR min(amount,WIDTH); ROR 0 if amount=0, else ((amount-1) mod WIDTH)+1.
REQ-020 Immediate mode (a = low log2(WIDTH) bits): LSL E=a; LSR/ASR E=WIDTH if a=0 else a; ROR a=0 SHALL be RRX (E=1, vacated MSB filled from carry_in), else E=a.
REQ-021 SHIFT: each cycle SHALL shift by k=min(STEP,remaining), decrement remaining by k; go DONE when remaining reaches 0.
REQ-022 Fill: LSL/LSR zeros, ASR copies of original MSB, ROR bits rotated out, RRX carry_in.
REQ-023 carry_out SHALL be last bit shifted out; E=0 SHALL give carry_out=carry_in and result=operand.
REQ-024 Latency: out_valid_out SHALL rise ceil(E/STEP)+1 cycles after accept edge (1 cycle when E=0).
REQ-025 DONE: result_out, carry_out SHALL hold stable while out_ready_in=0; on out_ready_in=1 go IDLE next cycle.
REQ-026 No request SHALL be accepted outside IDLE; in_valid_in ignored in SHIFT/DONE.
REQ-027 result_out/carry_out outside DONE SHALL be don't-care to consumers but never X after reset.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force IDLE, out_valid_out=0, in_ready_out=1 (one cycle after), result_out=0, carry_out=0, remaining=0.
REQ-029 Reset in SHIFT or DONE SHALL abandon the operation; no result is ever presented for it.

Verification
REQ-030 WIDTH=32,STEP=4: LSL reg amt 5, operand 0x8000_0001 -> result 0x0000_0020, carry 0, out_valid 3 cycles after accept.
REQ-031 LSR imm a=0, operand 0x8000_0000 -> result 0x0000_0000, carry 1, latency 9.
REQ-032 ROR imm a=0 (RRX), carry_in 1, operand 0x0000_0003 -> result 0x8000_0001, carry 1, latency 2.
REQ-033 ASR reg amt 40, operand 0x8000_0000 -> 0xFFFF_FFFF, carry 1; ROR reg amt 32, operand 0x8000_0000 -> 0x8000_0000, carry 1; LSL reg amt 33, operand 0xFFFF_FFFF -> 0, carry 0.
REQ-034 Backpressure: out_ready_in=0 for 3 cycles in DONE -> outputs stable, in_ready_out=0, new in_valid_in ignored; IDLE one cycle after out_ready_in=1.
REQ-035 Reset asserted mid-SHIFT (LSR amt 32) -> IDLE next cycle, out_valid_out never asserted; next request (LSL amt 0, carry_in 1) returns operand, carry 1, latency 1.
